bp_burst_mem_responder: RTL and testbench

BP_BURST_MEM_RESPONDER -- requirements
Module: bp_burst_mem_responder

---
 rtl/bp_burst_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_bp_burst_mem_responder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_burst_mem_responder.sv
// ---------------------------------------------------------------------------
// bp_burst_mem_responder_pkg
//   BedRock memory-header layout and message encodings shared by the
//   responder and anything that talks to it.
//
// bp_burst_mem_responder
//   Burst memory endpoint for a BedRock stream interface. It accepts one
//   command (header plus write beats) at a time, waits latency_p cycles,
//   echoes the header as the response, and returns read beats from a
//   word-addressed RAM.
//
//   Ports
//     clk_i, reset_i                      clock, synchronous active-high reset
//     mem_cmd_header_i/_v_i/_ready_and_o  command header channel
//     mem_cmd_data_i/_v_i/_ready_and_o    command (write) beat channel
//     mem_resp_header_o/_v_o/_ready_and_i response header channel
//     mem_resp_data_o/_v_o/_ready_and_i   response (read) beat channel
// ---------------------------------------------------------------------------
package bp_burst_mem_responder_pkg;

  typedef enum logic [3:0] {
    e_bp_unicore_cfg = 4'd0
  } bp_params_e;

  localparam int bp_payload_width_gp        = 16;
  localparam int bp_size_width_gp           = 3;
  localparam int bp_subop_width_gp          = 4;
  localparam int bp_msg_type_width_gp       = 4;
  localparam int bp_unicore_paddr_width_gp  = 40;

  localparam logic [3:0] e_bedrock_mem_rd    = 4'h0;
  localparam logic [3:0] e_bedrock_mem_wr    = 4'h1;
  localparam logic [3:0] e_bedrock_mem_uc_rd = 4'h2;
  localparam logic [3:0] e_bedrock_mem_uc_wr = 4'h3;
  localparam logic [3:0] e_bedrock_mem_pre   = 4'h4;
  localparam logic [3:0] e_bedrock_mem_amo   = 4'h5;

  // Size field is log2 of the transfer size in bytes.
  localparam logic [2:0] e_bedrock_msg_size_1   = 3'd0;
  localparam logic [2:0] e_bedrock_msg_size_2   = 3'd1;
  localparam logic [2:0] e_bedrock_msg_size_4   = 3'd2;
  localparam logic [2:0] e_bedrock_msg_size_8   = 3'd3;
  localparam logic [2:0] e_bedrock_msg_size_16  = 3'd4;
  localparam logic [2:0] e_bedrock_msg_size_32  = 3'd5;
  localparam logic [2:0] e_bedrock_msg_size_64  = 3'd6;
  localparam logic [2:0] e_bedrock_msg_size_128 = 3'd7;

  // Header for the unicore configuration, MSB first.
  typedef struct packed {
    logic [bp_payload_width_gp-1:0]       payload;
    logic [bp_size_width_gp-1:0]          size;
    logic [bp_unicore_paddr_width_gp-1:0] addr;
    logic [bp_subop_width_gp-1:0]         subop;
    logic [bp_msg_type_width_gp-1:0]      msg_type;
  } bp_bedrock_mem_header_s;

  function automatic int bp_paddr_width(input bp_params_e cfg);
    int w;
    case (cfg)
      e_bp_unicore_cfg: w = bp_unicore_paddr_width_gp;
      default:          w = bp_unicore_paddr_width_gp;
    endcase
    return w;
  endfunction

  function automatic int bp_mem_header_width(input bp_params_e cfg);
    return bp_payload_width_gp + bp_size_width_gp + bp_paddr_width(cfg)
         + bp_subop_width_gp + bp_msg_type_width_gp;
  endfunction

endpackage

module bp_burst_mem_responder
  import bp_burst_mem_responder_pkg::*;
#(
  parameter bp_params_e bp_params_p  = e_bp_unicore_cfg,
  parameter int         data_width_p = 64,
  parameter int         mem_els_p    = 1024,
  parameter int         latency_p    = 4
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,

  input  logic [bp_mem_header_width(bp_params_p)-1:0]  mem_cmd_header_i,
  input  logic                                         mem_cmd_header_v_i,
  output logic                                         mem_cmd_header_ready_and_o,
  input  logic [data_width_p-1:0]                      mem_cmd_data_i,
  input  logic                                         mem_cmd_data_v_i,
  output logic                                         mem_cmd_data_ready_and_o,

  output logic [bp_mem_header_width(bp_params_p)-1:0]  mem_resp_header_o,
  output logic                                         mem_resp_header_v_o,
  input  logic                                         mem_resp_header_ready_and_i,
  output logic [data_width_p-1:0]                      mem_resp_data_o,
  output logic                                         mem_resp_data_v_o,
  input  logic                                         mem_resp_data_ready_and_i
);

  localparam int header_width_lp = bp_mem_header_width(bp_params_p);
  localparam int paddr_width_lp  = bp_paddr_width(bp_params_p);
  localparam int bytes_lp        = data_width_p / 8;
  localparam int bytes_lg_lp     = $clog2(bytes_lp);
  localparam int ram_addr_w_lp   = $clog2(mem_els_p);
  localparam int lat_w_lp        = $clog2(latency_p + 1) + 1;
  // Wide enough for a 128-byte burst of single-byte beats.
  localparam int cnt_w_lp        = 9;

  // Header field positions (msg_type sits in the LSBs).
  localparam int addr_lsb_lp     = bp_msg_type_width_gp + bp_subop_width_gp;
  localparam int size_lsb_lp     = addr_lsb_lp + paddr_width_lp;
  localparam int word_lsb_lp     = addr_lsb_lp + bytes_lg_lp;

  localparam logic [2:0] e_ready       = 3'd0;
  localparam logic [2:0] e_cmd_data    = 3'd1;
  localparam logic [2:0] e_wait        = 3'd2;
  localparam logic [2:0] e_resp_header = 3'd3;
  localparam logic [2:0] e_resp_data   = 3'd4;

  function automatic logic [cnt_w_lp-1:0] beat_count(input logic [2:0] size);
    logic [cnt_w_lp-1:0] total_bytes;
    logic [cnt_w_lp-1:0] beats;
    total_bytes = cnt_w_lp'(1) << size;
    beats       = total_bytes >> bytes_lg_lp;
    if (beats == '0) beats = cnt_w_lp'(1);
    return beats;
  endfunction

  // Critical-word-first: step from the addressed word, wrapping inside the
  // size-aligned block of 'beats' words.
  function automatic logic [ram_addr_w_lp-1:0] wrap_index(
    input logic [ram_addr_w_lp-1:0] start,
    input logic [cnt_w_lp-1:0]      offset,
    input logic [cnt_w_lp-1:0]      beats
  );
    logic [ram_addr_w_lp-1:0] mask;
    mask = ram_addr_w_lp'(beats - cnt_w_lp'(1));
    return (start & ~mask) | ((start + ram_addr_w_lp'(offset)) & mask);
  endfunction

  // Sub-beat writes touch only their own byte lanes; the sender places the
  // data in its natural lanes (BedRock replicates narrow data across a beat).
  function automatic logic [bytes_lp-1:0] byte_mask(
    input logic [2:0]             size,
    input logic [bytes_lg_lp-1:0] offset
  );
    logic [bytes_lp-1:0]    lanes;
    logic [bytes_lg_lp-1:0] aligned;
    logic [bytes_lp-1:0]    result;
    if (int'(size) >= bytes_lg_lp) begin
      result = '1;
    end else begin
      lanes = '0;
      for (int i = 0; i < bytes_lp; i++) lanes[i] = (i < (1 << size));
      aligned = offset & ~bytes_lg_lp'((1 << size) - 1);
      result  = lanes << aligned;
    end
    return result;
  endfunction

  function automatic logic is_read_type(input logic [3:0] msg_type);
    return (msg_type == e_bedrock_mem_rd) || (msg_type == e_bedrock_mem_uc_rd);
  endfunction

  logic [2:0]                 state_r;
  logic [header_width_lp-1:0] header_r;
  logic [cnt_w_lp-1:0]        beat_cnt_r;
  logic [cnt_w_lp-1:0]        issue_cnt_r;
  logic [cnt_w_lp-1:0]        word_off_r;
  logic [lat_w_lp-1:0]        lat_cnt_r;
  logic                       vld_p1;
  logic [data_width_p-1:0]    rd_data_p1;
  logic [data_width_p-1:0]    mem_r [mem_els_p];

  logic                       cmd_hdr_ready;
  logic                       cmd_hdr_xfer;
  logic                       cmd_data_ready;
  logic                       cmd_data_xfer;
  logic                       resp_hdr_v;
  logic                       resp_hdr_xfer;
  logic                       resp_data_v;
  logic                       resp_data_xfer;
  logic                       rd_issue;
  logic                       hdr_is_read;
  logic [cnt_w_lp-1:0]        burst_beats;
  logic [ram_addr_w_lp-1:0]   cur_idx;
  logic [bytes_lp-1:0]        wr_mask;

  // Every ready/valid output is forced low while reset_i is held, even in
  // the cycle before the state register has been cleared.
  assign cmd_hdr_ready  = ~reset_i & (state_r == e_ready);
  assign cmd_hdr_xfer   = cmd_hdr_ready & mem_cmd_header_v_i;
  assign cmd_data_ready = ~reset_i & (state_r == e_cmd_data);
  assign cmd_data_xfer  = cmd_data_ready & mem_cmd_data_v_i;
  assign resp_hdr_v     = ~reset_i & (state_r == e_resp_header);
  assign resp_hdr_xfer  = resp_hdr_v & mem_resp_header_ready_and_i;
  assign resp_data_v    = ~reset_i & vld_p1;
  assign resp_data_xfer = resp_data_v & mem_resp_data_ready_and_i;

  assign hdr_is_read = is_read_type(header_r[bp_msg_type_width_gp-1:0]);
  assign burst_beats = beat_count(header_r[size_lsb_lp +: bp_size_width_gp]);
  assign cur_idx     = wrap_index(header_r[word_lsb_lp +: ram_addr_w_lp],
                                  word_off_r, burst_beats);
  assign wr_mask     = byte_mask(header_r[size_lsb_lp +: bp_size_width_gp],
                                 header_r[addr_lsb_lp +: bytes_lg_lp]);

  // Issue a RAM read whenever the output slot is empty or draining this
  // cycle, so the registered beat never gets overwritten while stalled.
  assign rd_issue = ~reset_i & (state_r == e_resp_data) & (issue_cnt_r != '0)
                  & (~vld_p1 | mem_resp_data_ready_and_i);

  assign mem_cmd_header_ready_and_o = cmd_hdr_ready;
  assign mem_cmd_data_ready_and_o   = cmd_data_ready;
  assign mem_resp_header_o          = header_r;
  assign mem_resp_header_v_o        = resp_hdr_v;
  assign mem_resp_data_o            = rd_data_p1;
  assign mem_resp_data_v_o          = resp_data_v;

  always_ff @(posedge clk_i) begin
    if (cmd_hdr_xfer) header_r <= mem_cmd_header_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= e_ready;
      beat_cnt_r  <= '0;
      issue_cnt_r <= '0;
      word_off_r  <= '0;
      lat_cnt_r   <= '0;
      vld_p1      <= 1'b0;
    end else begin
      case (state_r)
        e_ready: begin
          if (cmd_hdr_xfer) begin
            beat_cnt_r  <= beat_count(mem_cmd_header_i[size_lsb_lp +: bp_size_width_gp]);
            issue_cnt_r <= beat_count(mem_cmd_header_i[size_lsb_lp +: bp_size_width_gp]);
            word_off_r  <= '0;
            if (is_read_type(mem_cmd_header_i[bp_msg_type_width_gp-1:0])) begin
              state_r   <= e_wait;
              lat_cnt_r <= lat_w_lp'(latency_p);
            end else begin
              state_r   <= e_cmd_data;
            end
          end
        end
        e_cmd_data: begin
          if (cmd_data_xfer) begin
            word_off_r <= word_off_r + cnt_w_lp'(1);
            beat_cnt_r <= beat_cnt_r - cnt_w_lp'(1);
            if (beat_cnt_r == cnt_w_lp'(1)) begin
              state_r   <= e_wait;
              lat_cnt_r <= lat_w_lp'(latency_p);
            end
          end
        end
        e_wait: begin
          if (lat_cnt_r == '0) state_r   <= e_resp_header;
          else                 lat_cnt_r <= lat_cnt_r - lat_w_lp'(1);
        end
        e_resp_header: begin
          if (resp_hdr_xfer) state_r <= hdr_is_read ? e_resp_data : e_ready;
        end
        e_resp_data: begin
          if (rd_issue) begin
            word_off_r  <= word_off_r + cnt_w_lp'(1);
            issue_cnt_r <= issue_cnt_r - cnt_w_lp'(1);
          end
          if (resp_data_xfer) begin
            beat_cnt_r <= beat_cnt_r - cnt_w_lp'(1);
            if (beat_cnt_r == cnt_w_lp'(1)) state_r <= e_ready;
          end
        end
        default: state_r <= e_ready;
      endcase

      if (rd_issue)            vld_p1 <= 1'b1;
      else if (resp_data_xfer) vld_p1 <= 1'b0;
    end
  end

  // RAM: byte-masked write port, registered read port, never reset.
  always_ff @(posedge clk_i) begin
    if (cmd_data_xfer) begin
      for (int b = 0; b < bytes_lp; b++) begin
        if (wr_mask[b]) mem_r[cur_idx][8*b +: 8] <= mem_cmd_data_i[8*b +: 8];
      end
    end
    if (rd_issue) rd_data_p1 <= mem_r[cur_idx];
  end

endmodule

// File: tb/tb_bp_burst_mem_responder.sv
module tb_bp_burst_mem_responder;
  import bp_burst_mem_responder_pkg::*;

  localparam int HW = bp_mem_header_width(e_bp_unicore_cfg);

  logic          clk;
  logic          reset_i;
  logic [HW-1:0] cmd_header;
  logic          cmd_header_v;
  logic          cmd_header_ready;
  logic [63:0]   cmd_data;
  logic          cmd_data_v;
  logic          cmd_data_ready;
  logic [HW-1:0] resp_header;
  logic          resp_header_v;
  logic          resp_header_ready;
  logic [63:0]   resp_data;
  logic          resp_data_v;
  logic          resp_data_ready;

  int            n_cmp;
  int            n_fail;
  logic [63:0]   rx_beats [16];

  bp_burst_mem_responder #(
    .bp_params_p (e_bp_unicore_cfg),
    .data_width_p(64),
    .mem_els_p   (1024),
    .latency_p   (4)
  ) dut (
    .clk_i                      (clk),
    .reset_i                    (reset_i),
    .mem_cmd_header_i           (cmd_header),
    .mem_cmd_header_v_i         (cmd_header_v),
    .mem_cmd_header_ready_and_o (cmd_header_ready),
    .mem_cmd_data_i             (cmd_data),
    .mem_cmd_data_v_i           (cmd_data_v),
    .mem_cmd_data_ready_and_o   (cmd_data_ready),
    .mem_resp_header_o          (resp_header),
    .mem_resp_header_v_o        (resp_header_v),
    .mem_resp_header_ready_and_i(resp_header_ready),
    .mem_resp_data_o            (resp_data),
    .mem_resp_data_v_o          (resp_data_v),
    .mem_resp_data_ready_and_i  (resp_data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(300000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] msg, input logic [2:0] size,
                                           input logic [39:0] addr, input logic [15:0] payload);
    bp_bedrock_mem_header_s h;
    h          = '0;
    h.msg_type = msg;
    h.size     = size;
    h.addr     = addr;
    h.payload  = payload;
    return h;
  endfunction

  // Stimulus helpers: all start and end at 1 time unit after a rising edge.
  task automatic put_header(input logic [HW-1:0] h, output bit ok);
    ok = 0;
    cmd_header   = h;
    cmd_header_v = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_header_ready) ok = 1;
      @(posedge clk); #1;
    end
    cmd_header_v = 1'b0;
  endtask

  task automatic put_beat(input logic [63:0] d, output bit ok);
    ok = 0;
    cmd_data   = d;
    cmd_data_v = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_data_ready) ok = 1;
      @(posedge clk); #1;
    end
    cmd_data_v = 1'b0;
  endtask

  task automatic get_header(input int ready_pct, output logic [HW-1:0] h,
                            output bit ok, output int waits);
    ok = 0; waits = 0; h = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      resp_header_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (resp_header_v && resp_header_ready) begin
        h  = resp_header;
        ok = 1;
      end else if (!resp_header_v) begin
        waits++;
      end
      @(posedge clk); #1;
    end
    resp_header_ready = 1'b0;
  endtask

  task automatic get_beats(input int n, input int ready_pct, output int got, output bit stable);
    logic [63:0] held;
    bit          holding;
    got = 0; stable = 1; holding = 0; held = '0;
    for (int i = 0; i < 400 && got < n; i++) begin
      resp_data_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (resp_data_v) begin
        if (holding && resp_data !== held) stable = 0;
        if (resp_data_ready) begin
          rx_beats[got] = resp_data;
          got++;
          holding = 0;
        end else begin
          holding = 1;
          held    = resp_data;
        end
      end else if (holding) begin
        stable = 0;
      end
      @(posedge clk); #1;
    end
    resp_data_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmd_header_v = 1'b1;
    cmd_data_v   = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_header_ready !== 1'b0) begin n_fail++; $display("FAIL reset_hdr_ready: got %b want 0", cmd_header_ready); end
    n_cmp++; if (cmd_data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready: got %b want 0", cmd_data_ready); end
    n_cmp++; if (resp_header_v !== 1'b0) begin n_fail++; $display("FAIL reset_resp_hdr_v: got %b want 0", resp_header_v); end
    n_cmp++; if (resp_data_v !== 1'b0) begin n_fail++; $display("FAIL reset_resp_data_v: got %b want 0", resp_data_v); end
    @(posedge clk); #1;
    cmd_header_v = 1'b0;
    cmd_data_v   = 1'b0;
    reset_i      = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_header_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_hdr_ready: got %b want 1", cmd_header_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_dword;
    logic [HW-1:0] hw, hr, rh;
    bit ok, ok2, stable, early_ready;
    int waits, got;
    hw = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_8, 40'h80_0000_0010, 16'h00A1);
    hr = mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_8, 40'h80_0000_0010, 16'h00B2);
    // data valid before its header must simply wait
    cmd_data    = 64'hDEADBEEF_01234567;
    cmd_data_v  = 1'b1;
    early_ready = 0;
    repeat (2) begin
      @(negedge clk);
      if (cmd_data_ready) early_ready = 1;
      @(posedge clk); #1;
    end
    n_cmp++; if (early_ready !== 1'b0) begin n_fail++; $display("FAIL early_data_ready: got %b want 0", early_ready); end
    put_header(hw, ok);
    put_beat(64'hDEADBEEF_01234567, ok2);
    n_cmp++; if ((ok && ok2) !== 1'b1) begin n_fail++; $display("FAIL wr8_cmd_accept: got hdr=%b beat=%b want 1/1", ok, ok2); end
    get_header(100, rh, ok, waits);
    n_cmp++; if (!ok || rh !== hw) begin n_fail++; $display("FAIL wr8_resp_hdr: got %h (ok=%b) want %h", rh, ok, hw); end
    n_cmp++; if (waits !== 5) begin n_fail++; $display("FAIL wr8_latency: got %0d idle cycles want 5", waits); end
    put_header(hr, ok);
    get_header(100, rh, ok2, waits);
    n_cmp++; if (!ok || !ok2 || rh !== hr) begin n_fail++; $display("FAIL rd8_resp_hdr: got %h (ok=%b/%b) want %h", rh, ok, ok2, hr); end
    n_cmp++; if (waits !== 5) begin n_fail++; $display("FAIL rd8_latency: got %0d idle cycles want 5", waits); end
    get_beats(1, 100, got, stable);
    n_cmp++; if (got !== 1 || rx_beats[0] !== 64'hDEADBEEF_01234567) begin n_fail++; $display("FAIL rd8_data: got %h (beats=%0d) want deadbeef01234567", rx_beats[0], got); end
    @(negedge clk);
    n_cmp++; if (cmd_header_ready !== 1'b1 || resp_data_v !== 1'b0) begin n_fail++; $display("FAIL back_to_back_ready: got ready=%b data_v=%b want 1/0", cmd_header_ready, resp_data_v); end
    @(posedge clk); #1;
  endtask

  task automatic test_burst_wrap;
    logic [HW-1:0] hw, hr, rh;
    logic [63:0] exp_beats [8];
    bit ok, all_ok, stable;
    int waits, got;
    exp_beats = '{64'h3, 64'h4, 64'h5, 64'h6, 64'h7, 64'h0, 64'h1, 64'h2};
    hw = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h80_0000_0040, 16'h0C01);
    hr = mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h80_0000_0058, 16'h0C02);
    put_header(hw, all_ok);
    for (int i = 0; i < 8; i++) begin
      put_beat(64'(i), ok);
      all_ok = all_ok & ok;
    end
    n_cmp++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL wr64_cmd_accept: got %b want 1", all_ok); end
    get_header(100, rh, ok, waits);
    n_cmp++; if (!ok || rh !== hw) begin n_fail++; $display("FAIL wr64_resp_hdr: got %h want %h", rh, hw); end
    put_header(hr, ok);
    get_header(100, rh, ok, waits);
    n_cmp++; if (!ok || rh !== hr) begin n_fail++; $display("FAIL rd64_resp_hdr: got %h want %h", rh, hr); end
    get_beats(8, 100, got, stable);
    n_cmp++; if (got !== 8) begin n_fail++; $display("FAIL rd64_count: got %0d beats want 8", got); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rx_beats[i] !== exp_beats[i]) begin n_fail++; $display("FAIL rd64_wrap_beat%0d: got %h want %h", i, rx_beats[i], exp_beats[i]); end
    end
  endtask

  task automatic test_byte_write;
    logic [HW-1:0] rh;
    bit ok, ok2, ok3;
    int waits, got;
    bit stable;
    put_header(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_8, 40'h80_0000_0100, 16'h0001), ok);
    put_beat(64'hFFFFFFFF_FFFFFFFF, ok2);
    get_header(100, rh, ok3, waits);
    n_cmp++; if ((ok && ok2 && ok3) !== 1'b1) begin n_fail++; $display("FAIL ones_write: got %b%b%b want 111", ok, ok2, ok3); end
    put_header(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_1, 40'h80_0000_0103, 16'h0002), ok);
    put_beat(64'hAAAAAAAA_AAAAAAAA, ok2);
    get_header(100, rh, ok3, waits);
    put_header(mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_8, 40'h80_0000_0100, 16'h0003), ok);
    get_header(100, rh, ok2, waits);
    get_beats(1, 100, got, stable);
    n_cmp++; if (got !== 1 || rx_beats[0] !== 64'hFFFFFFFF_AAFFFFFF) begin n_fail++; $display("FAIL byte_write: got %h want ffffffffaaffffff", rx_beats[0]); end
    // 2-byte uncached write into bytes 6..7, then a 1-byte uncached read
    put_header(mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_2, 40'h80_0000_0106, 16'h0004), ok);
    put_beat(64'h55665566_55665566, ok2);
    get_header(100, rh, ok3, waits);
    put_header(mk_hdr(e_bedrock_mem_uc_rd, e_bedrock_msg_size_1, 40'h80_0000_0101, 16'h0005), ok);
    get_header(100, rh, ok2, waits);
    get_beats(1, 100, got, stable);
    n_cmp++; if (got !== 1 || rx_beats[0] !== 64'h5566FFFF_AAFFFFFF) begin n_fail++; $display("FAIL half_write_subword_read: got %h want 5566ffffaaffffff", rx_beats[0]); end
  endtask

  task automatic test_backpressure;
    logic [HW-1:0] hr, rh;
    bit ok, stable;
    int waits, got, extra;
    hr = mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h80_0000_0040, 16'h0D00);
    put_header(hr, ok);
    get_header(50, rh, ok, waits);
    n_cmp++; if (!ok || rh !== hr) begin n_fail++; $display("FAIL bp_resp_hdr: got %h want %h", rh, hr); end
    get_beats(8, 50, got, stable);
    n_cmp++; if (got !== 8) begin n_fail++; $display("FAIL bp_count: got %0d beats want 8", got); end
    n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b want 1", stable); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rx_beats[i] !== 64'(i)) begin n_fail++; $display("FAIL bp_beat%0d: got %h want %h", i, rx_beats[i], 64'(i)); end
    end
    extra = 0;
    resp_data_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (resp_data_v) extra++;
      @(posedge clk); #1;
    end
    resp_data_ready = 1'b0;
    n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL bp_no_duplicate: got %0d extra beats want 0", extra); end
  endtask

  task automatic test_reset_mid;
    logic [HW-1:0] hr, rh;
    bit ok, stable;
    int waits, got, stray;
    put_header(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h80_0000_0200, 16'h0E00), ok);
    for (int i = 0; i < 3; i++) put_beat(64'h99 + 64'(i), ok);
    reset_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_data_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_data_ready: got %b want 0", cmd_data_ready); end
    n_cmp++; if ({cmd_header_ready, resp_header_v, resp_data_v} !== 3'b000) begin n_fail++; $display("FAIL midreset_outputs: got %b want 000", {cmd_header_ready, resp_header_v, resp_data_v}); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    stray = 0;
    resp_header_ready = 1'b1;
    resp_data_ready   = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (resp_header_v || resp_data_v) stray++;
      @(posedge clk); #1;
    end
    resp_header_ready = 1'b0;
    resp_data_ready   = 1'b0;
    n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL midreset_stray_resp: got %0d want 0", stray); end
    hr = mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_8, 40'h80_0000_0010, 16'h0E01);
    put_header(hr, ok);
    get_header(100, rh, ok, waits);
    n_cmp++; if (!ok || rh !== hr) begin n_fail++; $display("FAIL postreset_hdr: got %h want %h", rh, hr); end
    get_beats(1, 100, got, stable);
    n_cmp++; if (got !== 1 || rx_beats[0] !== 64'hDEADBEEF_01234567) begin n_fail++; $display("FAIL postreset_data: got %h want deadbeef01234567", rx_beats[0]); end
  endtask

  task automatic test_alias;
    logic [HW-1:0] rh;
    bit ok, stable;
    int waits, got;
    put_header(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_8, 40'h80_0000_0000, 16'h0F00), ok);
    put_beat(64'h0BADF00D_CAFE1234, ok);
    get_header(100, rh, ok, waits);
    put_header(mk_hdr(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, 40'h80_0000_2000, 16'h0F01), ok);
    get_header(100, rh, ok, waits);
    get_beats(1, 100, got, stable);
    n_cmp++; if (got !== 1 || rx_beats[0] !== 64'h0BADF00D_CAFE1234) begin n_fail++; $display("FAIL alias_word0: got %h want 0badf00dcafe1234", rx_beats[0]); end
  endtask

  initial begin
    n_cmp             = 0;
    n_fail            = 0;
    reset_i           = 1'b1;
    cmd_header        = '0;
    cmd_header_v      = 1'b0;
    cmd_data          = '0;
    cmd_data_v        = 1'b0;
    resp_header_ready = 1'b0;
    resp_data_ready   = 1'b0;
    for (int i = 0; i < 16; i++) rx_beats[i] = '0;

    test_reset;
    test_single_dword;
    test_burst_wrap;
    test_byte_write;
    test_backpressure;
    test_reset_mid;
    test_alias;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
